// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 8-bit core: fetch, decode, execute, optional data access, write-back.
// Moore outputs only; a fetch or data request waiting past MAX_WAIT cycles for its ack parks the core in ERROR.
module cpu_sequencer #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter logic [7:0] MAX_WAIT = 8'd15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [7:0]  imem_rdata,
   output logic [7:0]  alu_instr,
   output logic [7:0]  alu_pc,
   input  logic [7:0]  alu_jump,
   input  logic [7:0]  alu_out,
   input  logic        alu_ovf,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic [1:0]  rf_wsel,
   output logic [1:0]  rf_waddr,
   output logic [7:0]  pc,
   output logic        busy,
   output logic        err,
   output logic        ovf_sticky,
   input  logic        ovf_clr,
   output logic [15:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
   } state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_pc, r_ir, r_wait, r_target;
   logic        r_taken, r_ovf, r_ovf_sticky;
   logic [15:0] r_retired;
   logic [3:0]  w_op;
   logic [7:0]  w_wait_inc;
   logic        w_timeout, w_is_jump, w_wr;

   assign w_op       = r_ir[7:4];
   assign w_wait_inc = r_wait + 8'd1;
   assign w_timeout  = (w_wait_inc == MAX_WAIT);
   assign w_is_jump  = (w_op == 4'h8) || (w_op == 4'h9) || (w_op == 4'hC) || (w_op == 4'hD);
   assign w_wr       = (w_op <= 4'h7) || (w_op == 4'h9) || (w_op == 4'hA) || (w_op >= 4'hE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (run) w_next = S_FETCH;
         S_FETCH:  if (imem_ack) w_next = S_DECODE;
                   else if (w_timeout) w_next = S_ERROR;
         S_DECODE: w_next = S_EXEC;
         S_EXEC:   w_next = ((w_op == 4'hA) || (w_op == 4'hB)) ? S_MEM : S_WB;
         S_MEM:    if (dmem_ack) w_next = S_WB;
                   else if (w_timeout) w_next = S_ERROR;
         S_WB:     w_next = run ? S_FETCH : S_IDLE;
         S_ERROR:  w_next = S_ERROR;
         default:  w_next = S_IDLE;
      endcase
   end

   // Jump decision and overflow are captured in EXEC so WB does not depend on the ALU holding its outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= RESET_PC;
         r_ir      <= 8'h00;
         r_wait    <= 8'd0;
         r_target  <= 8'h00;
         r_taken   <= 1'b0;
         r_ovf     <= 1'b0;
         r_retired <= 16'd0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_ack) begin
                  r_ir   <= imem_rdata;
                  r_wait <= 8'd0;
               end else begin
                  r_wait <= w_wait_inc;
               end
            end
            S_EXEC: begin
               r_taken  <= (alu_jump == 8'hFF) && w_is_jump;
               r_target <= r_pc + 8'd1 + alu_out;
               r_ovf    <= alu_ovf;
            end
            S_MEM:   r_wait <= dmem_ack ? 8'd0 : w_wait_inc;
            S_WB: begin
               r_pc      <= r_taken ? r_target : r_pc + 8'd1;
               r_retired <= r_retired + 16'd1;
            end
            default: r_wait <= 8'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          r_ovf_sticky <= 1'b0;
      else if ((r_state == S_WB) && (w_op == 4'h1) && r_ovf) r_ovf_sticky <= 1'b1;
      else if (ovf_clr)                                    r_ovf_sticky <= 1'b0;
   end

   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      rf_wsel  = 2'b00;
      rf_waddr = 2'b00;
      busy     = 1'b1;
      err      = 1'b0;
      case (r_state)
         S_IDLE:  busy = 1'b0;
         S_FETCH: imem_req = 1'b1;
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (w_op == 4'hB);
         end
         S_WB: begin
            rf_we = w_wr;
            if (w_op == 4'h9) begin
               rf_wsel  = 2'b10;
               rf_waddr = 2'b11;
            end else if (w_wr) begin
               rf_wsel  = (w_op == 4'hA) ? 2'b01 : 2'b00;
               rf_waddr = r_ir[3:2];
            end
         end
         S_ERROR: begin
            busy = 1'b0;
            err  = 1'b1;
         end
         default: ;
      endcase
   end

   assign imem_addr  = r_pc;
   assign alu_instr  = r_ir;
   assign alu_pc     = r_pc;
   assign pc         = r_pc;
   assign ovf_sticky = r_ovf_sticky;
   assign retired    = r_retired;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit core.
- Fetches each instruction over an imem req/ack handshake and presents it to the clocked ALU.
- Samples the ALU's jump/out/overflow results and runs the data-memory handshake for load word (LW) and store word (SW).
- Drives register-file write controls, updates the PC, and keeps status counters and flags.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- MAX_WAIT, 8'd15, max cycles a req may wait for ack before entering ERROR; legal range 1..255.

Ports:
- clk  input  1  core clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; enables fetching of new instructions.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  8  fetch address, always equal to pc.
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  8  fetched instruction.
- alu_instr  output  8  instruction register (ir) driven to the ALU.
- alu_pc  output  8  pc driven to the ALU.
- alu_jump  input  8  ALU jump result; 8'hFF means taken.
- alu_out  input  8  ALU result.
- alu_ovf  input  1  ALU overflow.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_ack  input  1  data memory done.
- rf_we  output  1  register-file write strobe, one cycle.
- rf_wsel  output  2  write-data select: 00 ALU out, 01 memory data, 10 pc+1 (link).
- rf_waddr  output  2  destination register.
- pc  output  8  current program counter.
- busy  output  1  high in any state except IDLE and ERROR.
- err  output  1  high in ERROR.
- ovf_sticky  output  1  accumulated signed-add overflow.
- ovf_clr  input  1  clears ovf_sticky.
- retired  output  16  count of completed instructions.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, ir=8'h00, retired=0, ovf_sticky=0.
  - All req/we outputs 0; rf_wsel=00; rf_waddr=00.
- Opcode is ir[7:4]. States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR.
- IDLE: run=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1; held until imem_ack.
  - On ack: ir<=imem_rdata, wait counter cleared, go to DECODE.
  - The wait counter increments on each cycle without ack. When it reaches MAX_WAIT -> ERROR.
- DECODE: one cycle; ir stable so the ALU samples it at the closing edge -> EXEC.
- EXEC:
  - Latch taken = (alu_jump==8'hFF) and opcode in {8,9,C,D}.
  - Latch target = pc + 8'd1 + alu_out, computed mod 256.
  - Opcode A or B -> MEM; otherwise -> WB.
- MEM:
  - dmem_req=1, dmem_we=(opcode==B), held until dmem_ack.
  - Same MAX_WAIT timeout rule as FETCH -> ERROR.
  - On ack -> WB.
- WB (one cycle):
  - rf_we=1 for opcodes 0-7, A, E, F with rf_waddr=ir[3:2].
  - rf_we=1 for opcode 9 with rf_waddr=2'b11 and rf_wsel=10.
  - No write for opcodes 8, B, C, D.
  - rf_wsel: 01 for opcode A, 10 for opcode 9, else 00.
  - pc <= taken ? target : pc+1; 8'hFF wraps to 8'h00.
  - retired increments and wraps at 16'hFFFF.
  - ovf_sticky set if opcode==1 and alu_ovf==1 (value latched in EXEC).
  - Next state: run=1 -> FETCH, else IDLE.
- ovf_clr: clears ovf_sticky next cycle. If set and clear occur in the same cycle, set wins.
- Latency with zero-wait acks: non-memory instruction takes 4 cycles (FETCH..WB); LW/SW take 5.
- run deasserted mid-instruction: the instruction completes through WB, then IDLE. No new fetch starts.
- ERROR:
  - err=1, busy=0, all req/we outputs 0.
  - pc and retired frozen.
  - Exit only via rst_n.
- Reset mid-operation: immediate return to reset values. Any outstanding req drops combinationally with the async reset.
- Outputs rf_we, imem_req, dmem_req decode from registered state only; no combinational path from ack inputs to req outputs.

Test Plan:
- Post-reset run=1, imem_rdata=8'h14, ack immediate, alu_ovf=1 in EXEC -> imem_req high in cycle 1 only; rf_we in cycle 4 with rf_waddr=01, rf_wsel=00; pc 00->01; retired=1; ovf_sticky=1.
- pc=8'h05, instr 8'h80, alu_jump=8'hFF, alu_out=8'h0A -> pc=8'h10 after WB; no rf_we. Same with alu_jump=8'h00 -> pc=8'h06.
- JAL 8'h90 at pc=8'hFF, alu_jump=8'hFF, alu_out=8'h00 -> rf_we with rf_waddr=11, rf_wsel=10; pc=8'h00. Non-jump at pc=8'hFF -> pc=8'h00.
- LW 8'hA8 with dmem_ack 3 cycles late -> dmem_req high 4 cycles, dmem_we=0; rf_we with rf_wsel=01, rf_waddr=10 the cycle after ack; 8 cycles total. SW 8'hB0 -> dmem_we=1, no rf_we.
- MAX_WAIT=4, imem_ack held 0 -> imem_req high 4 cycles, then err=1, busy=0, imem_req=0. State held with run=1 until rst_n pulse, then pc=RESET_PC.
- run dropped during EXEC -> WB completes, retired increments, then IDLE with busy=0 and no imem_req. ovf_clr asserted in the same cycle as an overflow WB -> ovf_sticky stays 1.
